// File: rtl/ifetch_queue.sv
// Instruction-fetch queue: issues in-order memory requests for incoming PCs and
// pairs returned instruction words with their PCs for decode, with flush support.
module ifetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instr,
  output logic              err_unexpected
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   PTR_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   PTR_ZERO = (PW+1)'(0);
  localparam logic [PW+1:0] DEPTH_V  = (PW+2)'(DEPTH);

  logic [PW:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW:0] fill_ptr_q, fill_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0] drop_cnt_q, drop_cnt_d;
  logic        err_q, err_d;

  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];

  logic [PW:0]   alloc_cnt, pend_cnt, ready_cnt, outstanding;
  logic [PW+1:0] occupancy;
  logic          deq;
  logic          pc_we, instr_we;

  assign alloc_cnt   = alloc_ptr_q - rd_ptr_q;
  assign pend_cnt    = alloc_ptr_q - fill_ptr_q;
  assign ready_cnt   = fill_ptr_q - rd_ptr_q;
  assign outstanding = drop_cnt_q + pend_cnt;
  assign occupancy   = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};

  // Slots still owed a stale response count against capacity, so in-flight requests never exceed DEPTH.
  assign pc_ready  = ~flush & ~reset & (occupancy < DEPTH_V);
  assign imem_req  = pc_valid & pc_ready;
  assign imem_addr = {pc_in[ADDR_W-1:2], 2'b00};

  assign id_valid       = (ready_cnt != PTR_ZERO);
  assign id_pc          = pc_mem[rd_ptr_q[PW-1:0]];
  assign id_instr       = instr_mem[rd_ptr_q[PW-1:0]];
  assign deq            = id_valid & id_ready & ~flush;
  assign err_unexpected = err_q;

  // Next-state for pointers, drop counter and error flag; flush overrides everything.
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    drop_cnt_d  = drop_cnt_q;
    err_d       = err_q;
    pc_we       = imem_req;
    instr_we    = 1'b0;
    if (flush) begin
      rd_ptr_d   = alloc_ptr_q;
      fill_ptr_d = alloc_ptr_q;
      if (imem_rvalid) begin
        if (outstanding != PTR_ZERO) begin
          drop_cnt_d = outstanding - PTR_ONE;
        end else begin
          drop_cnt_d = PTR_ZERO;
          err_d      = 1'b1;
        end
      end else begin
        drop_cnt_d = outstanding;
      end
    end else begin
      if (imem_req) begin
        alloc_ptr_d = alloc_ptr_q + PTR_ONE;
      end else begin
        alloc_ptr_d = alloc_ptr_q;
      end
      if (imem_rvalid) begin
        if (drop_cnt_q != PTR_ZERO) begin
          drop_cnt_d = drop_cnt_q - PTR_ONE;
        end else if (pend_cnt != PTR_ZERO) begin
          fill_ptr_d = fill_ptr_q + PTR_ONE;
          instr_we   = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alloc_ptr_q <= PTR_ZERO;
      fill_ptr_q  <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      drop_cnt_q  <= PTR_ZERO;
      err_q       <= 1'b0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_cnt_q  <= drop_cnt_d;
      err_q       <= err_d;
    end
  end

  // Entry storage, deliberately left unreset.
  always_ff @(posedge clk) begin
    if (pc_we) begin
      pc_mem[alloc_ptr_q[PW-1:0]] <= pc_in;
    end
    if (instr_we) begin
      instr_mem[fill_ptr_q[PW-1:0]] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order variable-latency memory model, scoreboard of
// accepted fetches, and directed scenarios for streaming, full, flush, wrap and error.
module tb_ifetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        err_unexpected;

  ifetch_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .err_unexpected(err_unexpected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_deliv = 0;
  int exp_deliv = 0;

  logic [31:0] exp_pc[$];
  logic [31:0] exp_ins[$];

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat = 1;
  logic        mem_drove = 1'b0;

  logic        req_s, pcr_s, idv_s, err_s, rv_s;
  logic [31:0] addr_s;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Snapshot DUT outputs mid-cycle, advance one edge, then run the memory model.
  task automatic tick();
    int due;
    @(negedge clk);
    req_s  = imem_req;
    addr_s = imem_addr;
    pcr_s  = pc_ready;
    idv_s  = id_valid;
    err_s  = err_unexpected;
    rv_s   = imem_rvalid;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_drove && mq_addr.size() > 0) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (req_s && !reset) begin
      due = cyc - 1 + lat;
      if (due <= last_due) due = last_due + 1;
      mq_addr.push_back(addr_s);
      mq_due.push_back(due);
      last_due = due;
    end
    mem_drove   = 1'b0;
    imem_rvalid = 1'b0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = data_of(mq_addr[0]);
      mem_drove   = 1'b1;
    end
  endtask

  // Scoreboard producer: record every accepted fetch, forget everything on flush/reset.
  always @(negedge clk) begin
    if (reset || flush) begin
      exp_pc.delete();
      exp_ins.delete();
    end else if (pc_valid && pc_ready) begin
      exp_pc.push_back(pc_in);
      exp_ins.push_back(data_of({pc_in[31:2], 2'b00}));
    end
  end

  // Scoreboard consumer: compare each consumed decode entry against the oldest expectation.
  always @(negedge clk) begin
    if (!reset && !flush && id_valid && id_ready) begin
      n_deliv++;
      if (exp_pc.size() == 0) begin
        n_total++;
        $display("FAIL sb_empty: got pc %0h expected no entry", id_pc);
      end else begin
        check("sb_pc", {32'd0, id_pc}, {32'd0, exp_pc.pop_front()});
        check("sb_instr", {32'd0, id_instr}, {32'd0, exp_ins.pop_front()});
      end
    end
  end

  initial begin
    logic [31:0] pcv;
    int issued;
    reset = 1'b1; pc_in = 32'd0; pc_valid = 1'b1; flush = 1'b0; id_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;

    // Reset state
    tick();
    check("rst_req", {63'd0, req_s}, 64'd0);
    check("rst_pc_ready", {63'd0, pcr_s}, 64'd0);
    check("rst_id_valid", {63'd0, idv_s}, 64'd0);
    check("rst_err", {63'd0, err_s}, 64'd0);
    reset = 1'b0; pc_valid = 1'b0;
    tick();
    check("post_rst_pc_ready", {63'd0, pcr_s}, 64'd1);

    // Streaming with latency-1 memory
    lat = 1; id_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pc_valid = 1'b1; pc_in = 32'(4 * k);
      tick();
      check("t2_req", {63'd0, req_s}, 64'd1);
      check("t2_addr", {32'd0, addr_s}, {32'd0, 32'(4 * k)});
      check("t2_id_valid", {63'd0, idv_s}, (k >= 2) ? 64'd1 : 64'd0);
    end
    pc_valid = 1'b0;
    repeat (4) tick();
    exp_deliv += 8;
    check("t2_deliv", 64'(n_deliv), 64'(exp_deliv));

    // Fill to capacity with decode stalled
    id_ready = 1'b0; issued = 0;
    for (int k = 0; k < 6; k++) begin
      pc_valid = 1'b1; pc_in = 32'(4 * issued);
      tick();
      if (req_s) issued++;
    end
    check("t3_issued", 64'(issued), 64'd4);
    check("t3_full_pc_ready", {63'd0, pcr_s}, 64'd0);
    pc_valid = 1'b0; id_ready = 1'b1;
    tick();
    check("t3_deq_id_valid", {63'd0, idv_s}, 64'd1);
    check("t3_no_bypass", {63'd0, pcr_s}, 64'd0);
    tick();
    check("t3_ready_back", {63'd0, pcr_s}, 64'd1);
    repeat (5) tick();
    exp_deliv += 4;
    check("t3_deliv", 64'(n_deliv), 64'(exp_deliv));

    // Flush with two latency-3 fetches in flight
    lat = 3; id_ready = 1'b1;
    pc_valid = 1'b1; pc_in = 32'h100; tick();
    check("t4_req0", {63'd0, req_s}, 64'd1);
    pc_in = 32'h104; tick();
    check("t4_req1", {63'd0, req_s}, 64'd1);
    flush = 1'b1; pc_in = 32'h108; tick();
    check("t4_flush_req", {63'd0, req_s}, 64'd0);
    check("t4_flush_pc_ready", {63'd0, pcr_s}, 64'd0);
    flush = 1'b0; pc_in = 32'h200; tick();
    check("t4_new_req", {63'd0, req_s}, 64'd1);
    pc_valid = 1'b0;
    repeat (8) tick();
    exp_deliv += 1;
    check("t4_deliv", 64'(n_deliv), 64'(exp_deliv));
    check("t4_err", {63'd0, err_s}, 64'd0);

    // Flush coinciding with response, dequeue and new PC
    lat = 2; id_ready = 1'b0; pc_valid = 1'b1;
    pc_in = 32'h300; tick();
    pc_in = 32'h304; tick();
    pc_in = 32'h308; tick();
    check("t5_req2", {63'd0, req_s}, 64'd1);
    flush = 1'b1; id_ready = 1'b1; pc_in = 32'h30C; tick();
    check("t5_flush_req", {63'd0, req_s}, 64'd0);
    check("t5_flush_id_valid", {63'd0, idv_s}, 64'd1);
    check("t5_flush_rvalid", {63'd0, rv_s}, 64'd1);
    flush = 1'b0; pc_in = 32'h400; tick();
    check("t5_after_id_valid", {63'd0, idv_s}, 64'd0);
    check("t5_after_req", {63'd0, req_s}, 64'd1);
    pc_valid = 1'b0;
    repeat (8) tick();
    exp_deliv += 1;
    check("t5_deliv", 64'(n_deliv), 64'(exp_deliv));
    check("t5_err", {63'd0, err_s}, 64'd0);

    // Pointer wrap with random decode stalls and latencies
    issued = 0;
    for (int k = 0; k < 200 && issued < 12; k++) begin
      pcv = 32'h1000 + 32'(4 * issued) + 32'(issued % 4);
      pc_valid = 1'b1; pc_in = pcv;
      lat = $urandom_range(1, 4);
      id_ready = 1'($urandom_range(0, 1));
      tick();
      if (req_s) begin
        check("t6_addr", {32'd0, addr_s}, {32'd0, pcv[31:2], 2'b00});
        issued++;
      end
    end
    check("t6_issued", 64'(issued), 64'd12);
    pc_valid = 1'b0; id_ready = 1'b1;
    repeat (24) tick();
    exp_deliv += 12;
    check("t6_deliv", 64'(n_deliv), 64'(exp_deliv));
    check("t6_sb_empty", 64'(exp_pc.size()), 64'd0);

    // Unexpected response sets a sticky error cleared only by reset
    check("t7_err_before", {63'd0, err_s}, 64'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    tick();
    check("t7_err_set", {63'd0, err_s}, 64'd1);
    repeat (3) tick();
    check("t7_err_sticky", {63'd0, err_s}, 64'd1);
    check("t7_no_deliv", 64'(n_deliv), 64'(exp_deliv));
    reset = 1'b1;
    mq_addr.delete(); mq_due.delete(); mem_drove = 1'b0; imem_rvalid = 1'b0;
    tick();
    check("t7_err_reset", {63'd0, err_s}, 64'd0);
    reset = 1'b0;
    tick();
    check("t7_err_after", {63'd0, err_s}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Accepts fetch addresses from the PC with a valid/ready handshake and issues in-order requests to instruction memory. Memory latency is variable, with a minimum of 1 cycle.
- Pairs each returned instruction word with its PC in a small circular queue, then presents (pc, instr) pairs to decode with a valid/ready handshake.
- Supports flush on branch/jump redirect, discarding queued and in-flight fetches.

Parameters:
- DEPTH, 4, number of queue entries. Must be a power of 2 and at least 2.
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction word width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- pc_in  input  ADDR_W  fetch address from the PC stage
- pc_valid  input  1  pc_in is valid
- pc_ready  output  1  fetch accepted this cycle when pc_valid && pc_ready
- imem_req  output  1  instruction-memory request strobe
- imem_addr  output  ADDR_W  word-aligned request address
- imem_rvalid  input  1  memory response valid; responses arrive in request order
- imem_rdata  input  DATA_W  memory response data
- flush  input  1  discard all queued and in-flight fetches
- id_valid  output  1  id_pc/id_instr valid for decode
- id_ready  input  1  decode consumes the head entry when id_valid && id_ready
- id_pc  output  ADDR_W  PC of the head entry
- id_instr  output  DATA_W  instruction of the head entry
- err_unexpected  output  1  sticky: a response arrived with nothing outstanding

Behaviour:
- State:
  - Pointers alloc_ptr, fill_ptr and rd_ptr, each clog2(DEPTH)+1 bits, with the MSB used as the wrap bit.
  - drop_cnt, clog2(DEPTH)+1 bits.
  - Per-entry pc and instr storage.
- Derived counts:
  - alloc_cnt = alloc_ptr - rd_ptr.
  - pend_cnt = alloc_ptr - fill_ptr.
  - ready_cnt = fill_ptr - rd_ptr.
- Reset (asynchronous):
  - All pointers, drop_cnt and err_unexpected clear to 0.
  - id_valid = 0 and imem_req = 0 while reset is asserted.
  - Entry storage is not reset.
- pc_ready = ~flush & ~reset & (alloc_cnt + drop_cnt < DEPTH).
  - Computed from registered state only. There is no same-cycle bypass from a decode dequeue.
- Request issue (combinational, zero latency):
  - imem_req = pc_valid & pc_ready.
  - imem_addr = {pc_in[ADDR_W-1:2], 2'b00}.
  - On a request: pc[alloc_ptr] <= pc_in and alloc_ptr++. The full pc_in, including low bits, is stored.
- Response handling, on imem_rvalid:
  - If drop_cnt > 0: decrement drop_cnt and discard the data.
  - Else if pend_cnt > 0: instr[fill_ptr] <= imem_rdata and fill_ptr++.
  - Else: set err_unexpected (sticky until reset) and discard the data.
  - Earliest response is the cycle after its request, giving id_valid at least 2 cycles after the request.
- Decode side:
  - id_valid = (ready_cnt != 0).
  - id_pc = pc[rd_ptr] and id_instr = instr[rd_ptr].
  - On id_valid & id_ready: rd_ptr++.
  - The head entry stays stable while id_valid && !id_ready.
- Simultaneous events with no flush:
  - Request, response and dequeue may all occur in one cycle.
  - Each pointer updates independently.
- Flush (synchronous, highest priority):
  - In the flush cycle pc_ready = 0, so no request is issued.
  - A dequeue in the flush cycle is ignored: the entry is dropped, not consumed.
  - rd_ptr <= alloc_ptr and fill_ptr <= alloc_ptr, so the queue becomes empty.
  - drop_cnt <= drop_cnt + pend_cnt - (imem_rvalid ? 1 : 0). The response in the flush cycle belongs to an old request and is discarded.
  - id_valid = 0 from the cycle after flush.
- New fetches after flush:
  - Accepted immediately the next cycle, subject to alloc_cnt + drop_cnt < DEPTH.
  - Ordering guarantees that stale responses are consumed by drop_cnt before new ones are filled.
- Boundary conditions:
  - Full when alloc_cnt + drop_cnt == DEPTH: pc_ready = 0, with no overflow.
  - Empty: id_valid = 0.
  - Pointer wrap-around is handled by the wrap bit, with no bubble at the wrap.
  - Total outstanding memory requests never exceed DEPTH.
- Reset mid-operation:
  - Abandons all state.
  - Responses returning after reset deassertion set err_unexpected. Memory must be reset together with this block.

Test Plan:
- Latency-1 memory with id_ready = 1 and pc_in = 0, 4, 8, … each cycle → imem_req every cycle; id_valid from cycle 2 with id_pc = 0, 4, 8 and matching id_instr; throughput 1/cycle.
- id_ready = 0 with DEPTH = 4 → exactly 4 requests, then pc_ready = 0; raise id_ready → entries drain in order 0, 4, 8, C; pc_ready returns the cycle after the first dequeue.
- Latency-3 memory, requests at 0x100 and 0x104, flush asserted one cycle later → both stale responses are discarded; the next fetch at 0x200 is delivered as id_pc = 0x200 with its own data.
- Flush in the same cycle as imem_rvalid, id_valid && id_ready, and pc_valid → no request issued, no dequeue counted, drop_cnt = pend_cnt - 1, id_valid = 0 the next cycle.
- Pointer wrap: run 3×DEPTH fetches with random id_ready and latency 1–4 → output order and pc/instr pairing are preserved with no loss or duplication.
- imem_rvalid pulse after reset with nothing outstanding → err_unexpected = 1 and stays set; reset clears it.
